// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, 8-bit LSB-first full-duplex transfers
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [6:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic             tick;

  // One tick per sck half-period; every phase change happens on a tick.
  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= 1'b0;
      ss      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) cnt <= '0;
      else                  cnt <= tick ? '0 : cnt + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            tx_sh   <= tx_data[7:1];
            mosi    <= tx_data[0];
            rx_sh   <= '0;
            ss      <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            sck   <= 1'b1;
            rx_sh <= {miso, rx_sh[7:1]};
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (tick) begin
            if (sck) begin
              sck <= 1'b0;
              if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                mosi  <= 1'b0;
                state <= ST_HOLD;
              end else begin
                mosi  <= tx_sh[0];
                tx_sh <= {1'b0, tx_sh[6:1]};
              end
            end else begin
              sck   <= 1'b1;
              rx_sh <= {miso, rx_sh[7:1]};
            end
          end
        end
        default: begin
          if (tick) begin
            ss      <= 1'b1;
            rx_data <= rx_sh;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed vector bench for spi_master
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst, start, miso;
  logic [7:0] tx_data, rx_data;
  logic       busy, done, sck, ss, mosi;

  logic       start2;
  logic [7:0] tx_data2, rx_data2;
  logic       busy2, done2, sck2, ss2, mosi2;

  int unsigned cyc = 0;
  int n_vec = 0;
  int n_fail = 0;

  logic [1:0] miso_mode;
  logic [7:0] per_dout, per_sh, per_rx, per_seen;
  logic [7:0] mosi_bits;
  int         rises;
  logic       overlap;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1) ? per_sh[0] : 1'b1;

  spi_master #(.CLK_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .tx_data(tx_data2), .rx_data(rx_data2),
    .busy(busy2), .done(done2), .sck(sck2), .ss(ss2), .mosi(mosi2), .miso(1'b1)
  );

  // Behavioural mode-0 peripheral: shifts out on sck fall, captures on sck rise.
  always @(negedge ss) per_sh = per_dout;
  always @(negedge sck) if (!ss) per_sh = {1'b0, per_sh[7:1]};
  always @(posedge sck) begin
    if (!ss) per_rx = {mosi, per_rx[7:1]};
    if (rises < 8) mosi_bits[rises] = mosi;
    rises++;
  end
  always @(posedge ss) per_seen = per_rx;

  typedef struct {
    logic [7:0] tx;
    logic [1:0] mode;
    logic [7:0] dout;
    logic [7:0] exp_rx;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input logic [7:0] tx, output int lat);
    int unsigned acc;
    @(negedge clk);
    tx_data = tx;
    start = 1'b1;
    rises = 0;
    mosi_bits = 8'h00;
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    tx_data = ~tx;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (busy && done) overlap = 1'b1;
      if (i == 20) start = 1'b1;
      if (i == 21) start = 1'b0;
      if (done) begin
        lat = int'(cyc - acc);
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int unsigned acc, r1, r2;
    logic bad, prev_sck, seen_done;

    vecs[0] = '{8'hA5, 2'd0, 8'h00, 8'hA5, 68};
    vecs[1] = '{8'h00, 2'd0, 8'h00, 8'h00, 68};
    vecs[2] = '{8'hFF, 2'd0, 8'h00, 8'hFF, 68};
    vecs[3] = '{8'h01, 2'd0, 8'h00, 8'h01, 68};
    vecs[4] = '{8'h80, 2'd0, 8'h00, 8'h80, 68};
    vecs[5] = '{8'h5A, 2'd2, 8'h00, 8'hFF, 68};
    vecs[6] = '{8'hC3, 2'd1, 8'h3C, 8'h3C, 68};

    rst = 1'b1; start = 1'b0; tx_data = 8'h00; miso_mode = 2'd0;
    start2 = 1'b0; tx_data2 = 8'h00; per_dout = 8'h00; per_sh = 8'h00;
    per_rx = 8'h00; per_seen = 8'h00; rises = 0; overlap = 1'b0; mosi_bits = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if ({ss, sck, mosi, busy, done, rx_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) bad = 1'b1;
    end
    chk("reset_idle_outputs", {31'd0, bad}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      miso_mode = vecs[v].mode;
      per_dout = vecs[v].dout;
      overlap = 1'b0;
      do_xfer(vecs[v].tx, lat);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("v%0d_rx_data", v), {24'd0, rx_data}, {24'd0, vecs[v].exp_rx});
      chk($sformatf("v%0d_sck_rises", v), 32'(rises), 32'd8);
      chk($sformatf("v%0d_mosi_bits", v), {24'd0, mosi_bits}, {24'd0, vecs[v].tx});
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", v), {30'd0, done, overlap}, 32'd0);
      if (vecs[v].mode == 2'd1) chk("periph_rx", {24'd0, per_seen}, 32'h0000_00C3);
    end

    // Start held high across two back-to-back transfers.
    miso_mode = 2'd0;
    @(negedge clk); tx_data = 8'h01; start = 1'b1;
    @(posedge clk); #1; acc = cyc;
    @(negedge clk); tx_data = 8'hFF;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = int'(cyc - acc); break; end
    end
    chk("b2b_first_lat", 32'(lat), 32'd68);
    chk("b2b_first_rx", {24'd0, rx_data}, 32'h0000_0001);
    chk("b2b_ss_high_done", {31'd0, ss}, 32'd1);
    @(posedge clk); #1; acc = cyc;
    chk("b2b_ss_low_next", {30'd0, ss, busy}, 32'd1);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = int'(cyc - acc); break; end
    end
    @(negedge clk); start = 1'b0;
    chk("b2b_second_lat", 32'(lat), 32'd68);
    chk("b2b_second_rx", {24'd0, rx_data}, 32'h0000_00FF);

    // Reset at E0+30 aborts the transfer.
    repeat (4) @(posedge clk);
    @(negedge clk); tx_data = 8'h3C; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {27'd0, ss, sck, busy, done, mosi}, 32'h10);
    chk("abort_rx_data", {24'd0, rx_data}, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen_done}, 32'd0);
    do_xfer(8'h96, lat);
    chk("after_abort_lat", 32'(lat), 32'd68);
    chk("after_abort_rx", {24'd0, rx_data}, 32'h0000_0096);

    // CLK_DIV=2 instance, miso tied high.
    @(negedge clk); tx_data2 = 8'h80; start2 = 1'b1;
    @(posedge clk); #1; acc = cyc; start2 = 1'b0;
    lat = -1; r1 = 0; r2 = 0; prev_sck = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sck2 && !prev_sck) begin
        if (r1 == 0) r1 = cyc; else if (r2 == 0) r2 = cyc;
      end
      prev_sck = sck2;
      if (done2) begin lat = int'(cyc - acc); break; end
    end
    chk("div2_sck_period", r2 - r1, 32'd4);
    chk("div2_latency", 32'(lat), 32'd34);
    chk("div2_rx_data", {24'd0, rx_data2}, 32'h0000_00FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
